// File: rtl/serial_frame_rx_if.sv
// Serial frame receiver bus: serial line in, word and status pulses out.
// Optional parity status under SERIAL_RX_PARITY_EN.
interface serial_frame_rx_if #(
   parameter int WIDTH = 4
);
   logic             D;
   logic [WIDTH-1:0] data_out;
   logic             valid;
   logic             frame_err;
   logic             busy;
`ifdef SERIAL_RX_PARITY_EN
   logic             parity_err;

   modport master (
      output D,
      input  data_out, valid, frame_err, busy, parity_err
   );

   modport slave (
      input  D,
      output data_out, valid, frame_err, busy, parity_err
   );
`else
   modport master (
      output D,
      input  data_out, valid, frame_err, busy
   );

   modport slave (
      input  D,
      output data_out, valid, frame_err, busy
   );
`endif
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start(1), WIDTH data bits MSB first, stop(0).
// Define SERIAL_RX_PARITY_EN to add an even-parity bit before the stop bit.
module serial_frame_rx #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   serial_frame_rx_if.slave   bus
);

`ifdef SERIAL_RX_PARITY_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_STOP = 2'd3
   } state_t;
`endif

   localparam logic [3:0] LAST = 4'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_data_out;
   logic             r_valid;
   logic             r_frame_err;
   logic             w_valid;
   logic             w_frame_err;
`ifdef SERIAL_RX_PARITY_EN
   logic             r_par;
   logic             r_parity_err;
   logic             w_parity_err;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.D) begin
               w_next = S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
               w_next = S_PARITY;
`else
               w_next = S_STOP;
`endif
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         S_PARITY: begin
            w_next = S_STOP;
         end
`endif
         S_STOP: begin
            // a bad stop bit is never reused as a start bit
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // output decode: pulses resolved at the stop-bit edge
   always_comb begin
      w_valid     = 1'b0;
      w_frame_err = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      w_parity_err = 1'b0;
`endif
      if (r_state == S_STOP) begin
         if (bus.D) begin
            w_frame_err = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
         end else if (r_par) begin
            w_parity_err = 1'b1;
`endif
         end else begin
            w_valid = 1'b1;
         end
      end
   end

   // datapath: counter, shift register, parity accumulator
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_shift <= '0;
`ifdef SERIAL_RX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
               r_par <= 1'b0;
`endif
            end
            S_DATA: begin
               r_shift <= {r_shift[WIDTH-2:0], bus.D};
               r_cnt   <= r_cnt + 4'd1;
`ifdef SERIAL_RX_PARITY_EN
               r_par   <= r_par ^ bus.D;
`endif
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PARITY: begin
               r_par <= r_par ^ bus.D;
            end
`endif
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_out  <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_valid     <= w_valid;
         r_frame_err <= w_frame_err;
`ifdef SERIAL_RX_PARITY_EN
         r_parity_err <= w_parity_err;
`endif
         if (w_valid) begin
            r_data_out <= r_shift;
         end
      end
   end

   assign bus.data_out  = r_data_out;
   assign bus.valid     = r_valid;
   assign bus.frame_err = r_frame_err;
   assign bus.busy      = (r_state != S_IDLE);
`ifdef SERIAL_RX_PARITY_EN
   assign bus.parity_err = r_parity_err;
`endif

endmodule
